// File: rtl/led_pkg.sv
// Shared types and helpers for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_t;

  // Clock cycles per half blink period (one blink_q toggle interval).
  function automatic int unsigned blink_div(input int unsigned clk_hz,
                                            input int unsigned blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running blink prescaler: counts 0..DIV-1 and toggles blink_q on the wrap edge.
// One instance is shared by all channels so every BLINK channel stays in phase.
module led_prescaler
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 48_000_000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic clk,
  input  logic reset,
  output logic blink_q,
  output logic tick
);

  localparam int unsigned Div  = blink_div(CLK_HZ, BLINK_HZ);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_d;

  // Wrap detect and next-state for the divider and the blink toggle.
  always_comb begin
    tick    = (cnt_q == CntW'(Div - 1));
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    blink_d = blink_q ^ tick;
  end

  // Divider counter and blink state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM-dim with registered outputs.
// Optional LED_INPUT_SYNC_EN: mode and duty pass through 2-flop synchronisers (3 clk latency).
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned CLK_HZ   = 48_000_000,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*N_CH-1:0]        mode,
  input  logic [PWM_BITS*N_CH-1:0] duty,
  output logic [N_CH-1:0]          led
);

  logic [2*N_CH-1:0]        mode_use;
  logic [PWM_BITS*N_CH-1:0] duty_use;

`ifdef LED_INPUT_SYNC_EN
  logic [2*N_CH-1:0]        mode_s1_q, mode_s2_q;
  logic [PWM_BITS*N_CH-1:0] duty_s1_q, duty_s2_q;

  // Two-flop synchronisers for inputs driven straight from board switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_s1_q <= '0;
      mode_s2_q <= '0;
      duty_s1_q <= '0;
      duty_s2_q <= '0;
    end else begin
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
      duty_s1_q <= duty;
      duty_s2_q <= duty_s1_q;
    end
  end

  assign mode_use = mode_s2_q;
  assign duty_use = duty_s2_q;
`else
  assign mode_use = mode;
  assign duty_use = duty;
`endif

  logic blink_q;
  logic blink_tick;

  led_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_HZ(BLINK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .blink_q(blink_q),
    .tick   (blink_tick)
  );

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_wrap;
  logic [PWM_BITS-1:0] duty_shadow_q [N_CH];
  logic [PWM_BITS-1:0] duty_shadow_d [N_CH];
  logic [N_CH-1:0]     led_q, led_d;
  logic                blink_now;

  // PWM counter next-state; duty shadows reload only at the period boundary so a
  // mid-period duty write never truncates or stretches the running period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    pwm_wrap  = &pwm_cnt_q;
    // Blink state as of this edge, so the pin toggles exactly DIV clk after reset release.
    blink_now = blink_q ^ blink_tick;
    for (int i = 0; i < int'(N_CH); i++) begin
      duty_shadow_d[i] = pwm_wrap ? duty_use[PWM_BITS*i +: PWM_BITS] : duty_shadow_q[i];
    end
  end

  // PWM counter and duty shadows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        duty_shadow_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      for (int i = 0; i < int'(N_CH); i++) begin
        duty_shadow_q[i] <= duty_shadow_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    logic      ch_led_d;
    led_mode_t ch_mode;

    // Per-channel mode mux; all-ones duty forces a constant-on output.
    always_comb begin
      ch_led_d = 1'b0;
      ch_mode  = led_mode_t'(mode_use[2*g +: 2]);
      unique case (ch_mode)
        LED_OFF:   ch_led_d = 1'b0;
        LED_ON:    ch_led_d = 1'b1;
        LED_BLINK: ch_led_d = blink_now;
        LED_PWM:   ch_led_d = (&duty_shadow_q[g]) ? 1'b1 : (pwm_cnt_q < duty_shadow_q[g]);
        default:   ch_led_d = 1'b0;
      endcase
    end

    assign led_d[g] = ch_led_d;
  end

  // Registered LED outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed self-checking bench for led_pattern_driver (CLK_HZ=20, BLINK_HZ=1 -> DIV=10).
// Honours LED_INPUT_SYNC_EN through the input latency LAT.
module tb_led_pattern_driver;

`ifdef LED_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic [5:0]  mode;
  logic [11:0] duty;
  logic [2:0]  led;

  int n_cmp;
  int n_err;
  int cyc;

  led_pattern_driver #(
    .N_CH    (3),
    .CLK_HZ  (20),
    .BLINK_HZ(1),
    .PWM_BITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mode (mode),
    .duty (duty),
    .led  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: step past the rising edge, sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Blink level seen on the pin after edge c since reset release.
  function automatic logic bexp(input int c);
    return ((c / 10) % 2) == 1;
  endfunction

  // PWM level after edge c for a shadow duty th (counter before edge c is (c-1)%16).
  function automatic logic pexp(input int c, input int th);
    return ((c - 1) % 16) < th;
  endfunction

  task automatic blink_chk();
    chk("blink_ch0", {2'b00, led[0]}, {2'b00, bexp(cyc)});
    chk("blink_ch1", {2'b00, led[1]}, {2'b00, bexp(cyc)});
  endtask

  logic [1:0] sweep [5];
  logic [1:0] m_now;
  logic       e;

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    sweep = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    // 1: reset held with all channels ON, then release.
    reset = 1'b0;
    mode  = 6'b01_01_01;
    duty  = 12'h000;
    repeat (5) begin
      tick();
      chk("rst_hold", led, 3'b000);
    end
    reset = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk("rst_release", led, (k == LAT) ? 3'b111 : 3'b000);
    end

    // 2: ch0 BLINK, ch1 joins later in phase.
    mode = 6'b01_01_10;
    while (cyc < 6) tick();
    while (cyc < 44) begin
      tick();
      chk("blink_ch0", {2'b00, led[0]}, {2'b00, bexp(cyc)});
      chk("on_ch2", {2'b00, led[2]}, 3'b001);
      if (cyc <= 20) chk("on_ch1", {2'b00, led[1]}, 3'b001);
      else if (cyc >= 20 + LAT) chk("blink_ch1_phase", {2'b00, led[1]}, {2'b00, bexp(cyc)});
      if (cyc == 20) mode = 6'b01_10_10;
    end

    // 3: ch2 PWM duty 5, then 0, then all-ones.
    mode = 6'b11_10_10;
    duty = 12'h500;
    while (cyc < 64) begin
      tick();
      blink_chk();
      if (cyc >= 49) chk("pwm_duty5", {2'b00, led[2]}, {2'b00, pexp(cyc, 5)});
    end
    duty = 12'h000;
    while (cyc < 96) begin
      tick();
      blink_chk();
      if (cyc >= 81) chk("pwm_duty0", {2'b00, led[2]}, 3'b000);
    end
    duty = 12'hF00;
    while (cyc < 128) begin
      tick();
      blink_chk();
      if (cyc >= 113) chk("pwm_dutyF", {2'b00, led[2]}, 3'b001);
    end

    // 4: duty 5 -> 12 written mid-period at pwm_cnt=8.
    duty = 12'h500;
    while (cyc < 176) begin
      tick();
      blink_chk();
      if (cyc >= 145)
        chk("pwm_duty_change", {2'b00, led[2]}, {2'b00, pexp(cyc, (cyc <= 160) ? 5 : 12)});
      if (cyc == 152) duty = 12'hC00;
    end
    while (cyc < 186) begin
      tick();
      blink_chk();
    end

    // 5: reset pulse at prescaler count 6.
    reset = 1'b0;
    #1;
    chk("rst_async", led, 3'b000);
    repeat (2) begin
      tick();
      chk("rst_pulse", led, 3'b000);
    end
    reset = 1'b1;
    cyc   = 0;
    while (cyc < 32) begin
      tick();
      chk("blink_after_rst", {1'b0, led[1:0]}, {1'b0, bexp(cyc), bexp(cyc)});
      chk("pwm_after_rst", {2'b00, led[2]}, {2'b00, (cyc > 16) && pexp(cyc, 12)});
    end

    // 6: ch0 mode sweep every 7 clk, ch1/ch2 held ON.
    mode = 6'b01_01_00;
    duty = 12'hC03;
    while (cyc < 40) tick();
    for (int c = 0; c < 35; c++) begin
      m_now = sweep[c / 7];
      if (c % 7 == 0) mode[1:0] = m_now;
      tick();
      chk("sweep_hold_ch12", {led[2:1], 1'b0}, 3'b110);
      if (c % 7 >= LAT - 1) begin
        case (m_now)
          2'b00:   e = 1'b0;
          2'b01:   e = 1'b1;
          2'b10:   e = bexp(cyc);
          default: e = pexp(cyc, 3);
        endcase
        chk("sweep_ch0", {2'b00, led[0]}, {2'b00, e});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
